mem_stage_lsu: RTL and testbench



---
 rtl/mem_stage_lsu_pkg.sv | 45 ++++
 rtl/mem_stage_lsu_if.sv | 27 ++
 rtl/mem_stage_lsu_data_align.sv | 45 ++++
 rtl/mem_stage_lsu.sv | 187 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit: func3 codes,
// FSM state enum, access-size offset masking and reset defaults.
package mem_stage_lsu_pkg;

  // Load func3 codes; 3'b111 is decoded as a full doubleword (falls to default).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Access size is func3[1:0] for both loads and stores.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [63:0] RESET_IDLE_DATA_DEF = 64'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  // Forces the byte offset onto the natural boundary of the access size.
  function automatic logic [2:0] mask_off(input logic [1:0] size, input logic [2:0] off);
    logic [2:0] m;
    case (size)
      SZ_B:    m = off;
      SZ_H:    m = off & 3'b110;
      SZ_W:    m = off & 3'b100;
      SZ_D:    m = 3'b000;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    return off != mask_off(size, off);
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the LSU (master) and a synchronous 64-bit memory (slave).
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32
);
  // req is held with we/addr/wdata/be stable until the cycle gnt is seen with
  // req high; that cycle is the transfer. A read returns exactly one rvalid
  // pulse with rdata at some later cycle. gnt/rvalid without a pending
  // request/read carry no meaning.
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       wdata;
  logic [7:0]        be;
  logic              gnt;
  logic              rvalid;
  logic [63:0]       rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage_lsu_data_align.sv
// Purely combinational lane steering: load shift plus sign/zero extension,
// store data shift and byte-enable generation.
module mem_stage_lsu_data_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [2:0]  ld_func3,
  input  logic [2:0]  ld_off,
  input  logic [63:0] ld_rdata,
  output logic [63:0] ld_data,
  input  logic [1:0]  st_size,
  input  logic [2:0]  st_off,
  input  logic [63:0] st_wdata_in,
  output logic [63:0] st_wdata,
  output logic [7:0]  st_be
);

  logic [63:0] ld_shifted;
  logic [7:0]  st_be_base;

  always_comb begin
    ld_shifted = ld_rdata >> {ld_off, 3'b000};
    case (ld_func3)
      F3_LB:   ld_data = {{56{ld_shifted[7]}},  ld_shifted[7:0]};
      F3_LH:   ld_data = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_LW:   ld_data = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
      F3_LD:   ld_data = ld_shifted;
      F3_LBU:  ld_data = {56'd0, ld_shifted[7:0]};
      F3_LHU:  ld_data = {48'd0, ld_shifted[15:0]};
      F3_LWU:  ld_data = {32'd0, ld_shifted[31:0]};
      default: ld_data = ld_shifted;
    endcase
  end

  always_comb begin
    case (st_size)
      SZ_B:    st_be_base = 8'h01;
      SZ_H:    st_be_base = 8'h03;
      SZ_W:    st_be_base = 8'h0F;
      default: st_be_base = 8'hFF;
    endcase
    st_be    = st_be_base << st_off;
    st_wdata = st_wdata_in << {st_off, 3'b000};
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: IDLE/REQ/WAIT FSM driving the data-memory bus,
// pipeline stall and the registered write-back payload. Optional: MISALIGN_TRAP_EN.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int          ADDR_W          = 32,
  parameter logic [63:0] RESET_IDLE_DATA = RESET_IDLE_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_func3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [63:0]       ex_result,
  input  logic [63:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              stall,
  mem_stage_lsu_if.master   dmem,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [63:0]       wb_data,
  output logic              misalign,
  output lsu_state_e        dbg_state
);

  lsu_state_e        state_q, state_d;
  logic [2:0]        func3_q, func3_d;
  logic [2:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [63:0]       req_wdata_q, req_wdata_d;
  logic [7:0]        req_be_q, req_be_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_q, wb_we_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [63:0]       wb_data_q, wb_data_d;
  logic              misalign_q, misalign_d;

  logic              mem_op;
  logic              ex_store;
  logic [1:0]        ex_size;
  logic [2:0]        ex_off;
  logic              trap;
  logic [63:0]       ld_data;
  logic [63:0]       st_wdata;
  logic [7:0]        st_be;

  // A request flagged as both load and store is handled as a load.
  assign mem_op   = ex_valid & (ex_is_load | ex_is_store);
  assign ex_store = ex_is_store & ~ex_is_load;
  assign ex_size  = ex_func3[1:0];
  assign ex_off   = mask_off(ex_size, ex_addr[2:0]);

`ifdef MISALIGN_TRAP_EN
  assign trap = mem_op & is_misaligned(ex_size, ex_addr[2:0]);
`else
  assign trap = 1'b0;
`endif

  mem_stage_lsu_data_align u_align (
    .ld_func3    (func3_q),
    .ld_off      (off_q),
    .ld_rdata    (dmem.rdata),
    .ld_data     (ld_data),
    .st_size     (ex_size),
    .st_off      (ex_off),
    .st_wdata_in (ex_wdata),
    .st_wdata    (st_wdata),
    .st_be       (st_be)
  );

  always_comb begin
    state_d     = state_q;
    func3_d     = func3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    misalign_d  = 1'b0;
    stall       = 1'b0;

    case (state_q)
      IDLE: begin
        if (trap) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = ex_rd;
          misalign_d = 1'b1;
        end else if (mem_op) begin
          // Bus fields are captured here so they stay put however long gnt takes.
          stall       = 1'b1;
          func3_d     = ex_func3;
          off_d       = ex_off;
          rd_d        = ex_rd;
          req_we_d    = ex_store;
          req_addr_d  = {ex_addr[ADDR_W-1:3], 3'b000};
          req_wdata_d = st_wdata;
          req_be_d    = st_be;
          state_d     = REQ;
        end else if (ex_valid) begin
          wb_valid_d = 1'b1;
          wb_we_d    = (ex_rd != 5'd0);
          wb_rd_d    = ex_rd;
          wb_data_d  = ex_result;
        end
      end
      REQ: begin
        stall = ~(dmem.gnt & req_we_q);
        if (dmem.gnt) begin
          if (req_we_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            state_d    = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall = ~dmem.rvalid;
        if (dmem.rvalid) begin
          wb_valid_d = 1'b1;
          wb_we_d    = (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          wb_data_d  = ld_data;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      func3_q     <= 3'd0;
      off_q       <= 3'd0;
      rd_q        <= 5'd0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= 64'd0;
      req_be_q    <= 8'd0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= RESET_IDLE_DATA;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      func3_q     <= func3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
    end
  end

  assign dmem.req   = (state_q == REQ);
  assign dmem.we    = req_we_q;
  assign dmem.addr  = req_addr_q;
  assign dmem.wdata = req_wdata_q;
  assign dmem.be    = req_be_q;

  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign misalign  = misalign_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed + light random bench for mem_stage_lsu; write-back payloads are
// checked against an expected queue, bus/stall behaviour with immediate asserts.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  logic              ex_is_load;
  logic              ex_is_store;
  logic [2:0]        ex_func3;
  logic [ADDR_W-1:0] ex_addr;
  logic [63:0]       ex_result;
  logic [63:0]       ex_wdata;
  logic [4:0]        ex_rd;
  logic              stall;
  logic              wb_valid;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [63:0]       wb_data;
  logic              misalign;
  lsu_state_e        dbg_state;

  mem_stage_lsu_if #(.ADDR_W(ADDR_W)) dmem_if ();

  mem_stage_lsu #(.ADDR_W(ADDR_W), .RESET_IDLE_DATA(64'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_is_load  (ex_is_load),
    .ex_is_store (ex_is_store),
    .ex_func3    (ex_func3),
    .ex_addr     (ex_addr),
    .ex_result   (ex_result),
    .ex_wdata    (ex_wdata),
    .ex_rd       (ex_rd),
    .stall       (stall),
    .dmem        (dmem_if),
    .wb_valid    (wb_valid),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .misalign    (misalign),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // {check_rd_data, misalign, we, rd[4:0], data[63:0]}
  logic [71:0] exp_q[$];
  logic [71:0] mon_e;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 64'(wb_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wb_we", 64'(wb_we), 64'(mon_e[69]));
          chk("wb_misalign", 64'(misalign), 64'(mon_e[70]));
          if (mon_e[71]) begin
            chk("wb_rd", 64'(wb_rd), 64'(mon_e[68:64]));
            chk("wb_data", wb_data, mon_e[63:0]);
          end
        end
      end else if (misalign) begin
        chk("misalign_no_wb", 64'(misalign), 64'd0);
      end
    end
  end

  // ---------------- reference helpers ----------------
  function automatic logic [2:0] tb_off(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      2'd0:    return a;
      2'd1:    return {a[2:1], 1'b0};
      2'd2:    return {a[2], 2'b00};
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [63:0] ld_model(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [63:0] rdat);
    logic [63:0] v;
    int nb;
    int off;
    nb  = 1 << f3[1:0];
    off = int'(tb_off(f3[1:0], a[2:0]));
    v   = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rdat[8*(off+i) +: 8];
    if (!f3[2] && nb < 8 && v[8*nb-1]) begin
      for (int i = 8*nb; i < 64; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [63:0] res);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_rd = rd; ex_result = res; ex_func3 = 3'($urandom_range(0, 7));
    exp_q.push_back({1'b1, 1'b0, (rd != 5'd0), rd, res});
    @(negedge clk);
    chk("alu_stall", 64'(stall), 64'd0);
    chk("alu_req", 64'(dmem_if.req), 64'd0);
    tick();
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [63:0] rdat,
                         input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                         input logic [63:0] exp_data);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0;
    ex_func3 = f3; ex_addr = addr; ex_rd = rd; ex_result = {$urandom(), $urandom()};
    exp_q.push_back({1'b1, 1'b0, (rd != 5'd0), rd, exp_data});
    @(negedge clk);
    chk("ld_accept_stall", 64'(stall), 64'd1);
    chk("ld_accept_req", 64'(dmem_if.req), 64'd0);
    tick();
    ex_addr = $urandom(); ex_func3 = 3'($urandom_range(0, 7)); ex_rd = 5'($urandom_range(0, 31));
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk);
      chk("ld_req_wait", 64'(dmem_if.req), 64'd1);
      chk("ld_stall_req", 64'(stall), 64'd1);
      tick();
    end
    dmem_if.gnt = 1'b1;
    @(negedge clk);
    chk("ld_req", 64'(dmem_if.req), 64'd1);
    chk("ld_we", 64'(dmem_if.we), 64'd0);
    chk("ld_addr", 64'(dmem_if.addr), 64'({addr[31:3], 3'b000}));
    chk("ld_stall_gnt", 64'(stall), 64'd1);
    tick();
    dmem_if.gnt = 1'b0;
    for (int i = 0; i < rv_dly; i++) begin
      @(negedge clk);
      chk("ld_wait_req", 64'(dmem_if.req), 64'd0);
      chk("ld_stall_wait", 64'(stall), 64'd1);
      tick();
    end
    dmem_if.rvalid = 1'b1;
    dmem_if.rdata  = rdat;
    @(negedge clk);
    chk("ld_stall_done", 64'(stall), 64'd0);
    tick();
    dmem_if.rvalid = 1'b0;
    dmem_if.rdata  = {$urandom(), $urandom()};
    go_idle();
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [63:0] wd,
                          input int gnt_dly, input logic [7:0] exp_be,
                          input logic [63:0] exp_wd, input logic [31:0] exp_addr);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b1;
    ex_func3 = f3; ex_addr = addr; ex_wdata = wd; ex_rd = 5'($urandom_range(0, 31));
    exp_q.push_back({1'b0, 1'b0, 1'b0, 5'd0, 64'd0});
    @(negedge clk);
    chk("st_accept_stall", 64'(stall), 64'd1);
    chk("st_accept_req", 64'(dmem_if.req), 64'd0);
    tick();
    for (int i = 0; i < gnt_dly; i++) begin
      ex_wdata = {$urandom(), $urandom()}; ex_addr = $urandom();
      @(negedge clk);
      chk("st_req_wait", 64'(dmem_if.req), 64'd1);
      chk("st_stall_req", 64'(stall), 64'd1);
      chk("st_be_hold", 64'(dmem_if.be), 64'(exp_be));
      chk("st_wdata_hold", dmem_if.wdata, exp_wd);
      tick();
    end
    dmem_if.gnt = 1'b1;
    @(negedge clk);
    chk("st_req", 64'(dmem_if.req), 64'd1);
    chk("st_we", 64'(dmem_if.we), 64'd1);
    chk("st_addr", 64'(dmem_if.addr), 64'(exp_addr));
    chk("st_be", 64'(dmem_if.be), 64'(exp_be));
    chk("st_wdata", dmem_if.wdata, exp_wd);
    chk("st_stall_gnt", 64'(stall), 64'd0);
    tick();
    dmem_if.gnt = 1'b0;
    go_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [31:0] addr;
    logic [63:0] rdat;
    logic [63:0] wd;
    logic [4:0]  rd;
    int          nb;

    rst = 1'b1;
    go_idle();
    ex_func3 = 3'd0; ex_addr = '0; ex_result = 64'd0; ex_wdata = 64'd0; ex_rd = 5'd0;
    dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0; dmem_if.rdata = 64'd0;
    repeat (3) tick();

    // Reset values
    @(negedge clk);
    chk("rst_req", 64'(dmem_if.req), 64'd0);
    chk("rst_we", 64'(dmem_if.we), 64'd0);
    chk("rst_be", 64'(dmem_if.be), 64'd0);
    chk("rst_addr", 64'(dmem_if.addr), 64'd0);
    chk("rst_wdata", dmem_if.wdata, 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_we", 64'(wb_we), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    tick();
    rst = 1'b0;
    tick();

    // LW / LBU / LB from the same doubleword
    do_load(3'b010, 32'h104, 64'h8765_4321_DEAD_BEEF, 5'd7, 0, 0, 64'hFFFF_FFFF_8765_4321);
    tick();
    do_load(3'b100, 32'h107, 64'h8765_4321_DEAD_BEEF, 5'd8, 0, 0, 64'h0000_0000_0000_0087);
    tick();
    do_load(3'b000, 32'h107, 64'h8765_4321_DEAD_BEEF, 5'd9, 1, 2, 64'hFFFF_FFFF_FFFF_FF87);
    tick();

    // SH with a 3-cycle grant delay
    do_store(3'b001, 32'h206, 64'h0000_0000_0000_ABCD, 3, 8'hC0, 64'hABCD_0000_0000_0000, 32'h200);
    @(negedge clk);
    chk("st_after_req", 64'(dmem_if.req), 64'd0);
    tick();

    // ADD then LD with rd=0, back to back
    do_alu(5'd5, 64'd42);
    do_load(3'b011, 32'h400, 64'h0123_4567_89AB_CDEF, 5'd0, 0, 1, 64'h0123_4567_89AB_CDEF);
    tick();

    // Reset while in WAIT, then a stray rvalid
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0;
    ex_func3 = 3'b011; ex_addr = 32'h108; ex_rd = 5'd3;
    tick();
    dmem_if.gnt = 1'b1;
    tick();
    dmem_if.gnt = 1'b0;
    go_idle();
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_state", 64'(dbg_state), 64'(WAIT));
    tick();
    rst = 1'b0;
    dmem_if.rvalid = 1'b1;
    dmem_if.rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
    @(negedge clk);
    chk("post_rst_state", 64'(dbg_state), 64'(IDLE));
    chk("post_rst_req", 64'(dmem_if.req), 64'd0);
    chk("post_rst_stall", 64'(stall), 64'd0);
    tick();
    dmem_if.rvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("post_rst_state2", 64'(dbg_state), 64'(IDLE));
    tick();

    // SW at a misaligned address
`ifdef MISALIGN_TRAP_EN
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b1;
    ex_func3 = 3'b010; ex_addr = 32'h302; ex_wdata = 64'h1122_3344_5566_7788; ex_rd = 5'd0;
    exp_q.push_back({1'b0, 1'b1, 1'b0, 5'd0, 64'd0});
    @(negedge clk);
    chk("trap_stall", 64'(stall), 64'd0);
    chk("trap_req", 64'(dmem_if.req), 64'd0);
    tick();
    go_idle();
    @(negedge clk);
    chk("trap_req_next", 64'(dmem_if.req), 64'd0);
    chk("trap_pulse", 64'(misalign), 64'd1);
    chk("trap_wb_valid", 64'(wb_valid), 64'd1);
    tick();
    @(negedge clk);
    chk("trap_pulse_end", 64'(misalign), 64'd0);
    tick();
`else
    do_store(3'b010, 32'h302, 64'h1122_3344_5566_7788, 0, 8'h0F, 64'h1122_3344_5566_7788, 32'h300);
    @(negedge clk);
    chk("sw_misalign_flag", 64'(misalign), 64'd0);
    tick();
`endif

    // Random mix of ALU ops, loads and stores
    for (int it = 0; it < 12; it++) begin
      f3   = 3'($urandom_range(0, 7));
      off  = 3'($urandom_range(0, 7));
`ifdef MISALIGN_TRAP_EN
      off  = tb_off(f3[1:0], off);
`endif
      addr = ($urandom() & 32'h0000_0FF8) | {29'd0, off};
      rdat = {$urandom(), $urandom()};
      wd   = {$urandom(), $urandom()};
      rd   = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 2))
        0: do_alu(rd, rdat);
        1: do_load(f3, addr, rdat, rd, $urandom_range(0, 2), $urandom_range(0, 2),
                   ld_model(f3, addr, rdat));
        default: begin
          nb = 1 << f3[1:0];
          do_store(f3, addr, wd, $urandom_range(0, 2),
                   8'(((1 << nb) - 1) << tb_off(f3[1:0], off)),
                   wd << (8 * tb_off(f3[1:0], off)),
                   {addr[31:3], 3'b000});
        end
      endcase
    end
    go_idle();
    repeat (3) tick();

    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
